// File: rtl/risk_order_sequencer.sv
// risk_order_sequencer: round-robin order sequencer with fat-finger, kill and rate-throttle risk checks
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   req_valid/req_ready      per-requester order handshake (req_ready is a one-hot accept pulse)
//   req_price/req_qty        packed per-requester price (32b) and quantity (16b)
//   price_limit              fat-finger price ceiling, sampled in CHECK
//   kill, rearm              level kill switch; one-cycle pulse that leaves HALT
//   out_*                    approved order to the encoder (valid/ready)
//   rej_valid/rej_src/code   one-cycle reject report (1 price, 2 qty, 3 killed)
//   halted, throttled        status flags
// Optional: define RISK_SEQ_STATS_EN to add saturating stat_* counters as extra outputs.
module risk_order_sequencer #(
    parameter int unsigned N_REQ         = 4,
    parameter logic [15:0] MAX_QTY       = 16'd10000,
    parameter int unsigned WINDOW_CYCLES = 1000,
    parameter int unsigned MAX_ORDERS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_price,
    input  logic [16*N_REQ-1:0]  req_qty,
    input  logic [31:0]          price_limit,
    input  logic                 kill,
    input  logic                 rearm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_price,
    output logic [15:0]          out_qty,
    output logic [2:0]           out_src,
    output logic                 rej_valid,
    output logic [2:0]           rej_src,
    output logic [1:0]           rej_code,
    output logic                 halted,
    output logic                 throttled
`ifdef RISK_SEQ_STATS_EN
    ,
    output logic [31:0]          stat_accepted,
    output logic [31:0]          stat_rej_price,
    output logic [31:0]          stat_rej_qty,
    output logic [31:0]          stat_killed
`endif
);
    typedef enum logic [1:0] {IDLE, CHECK, ISSUE, HALT} state_t;
    state_t state, nxt;
    logic [2:0] rr_ptr, gnt;
    logic gnt_any, grant, hs, wrap, rej_n;
    logic [1:0] code_n;
    logic [31:0] win_cnt, ord_cnt, h_price;
    logic [15:0] h_qty;
    logic [2:0] h_src;
    int j;

    assign out_valid = state == ISSUE;
    assign out_price = h_price;
    assign out_qty   = h_qty;
    assign out_src   = h_src;
    assign halted    = state == HALT;
    assign throttled = ord_cnt == MAX_ORDERS;
    assign hs        = out_valid && out_ready;
    assign wrap      = win_cnt == WINDOW_CYCLES - 1;
    assign grant     = state == IDLE && !rst && !kill && !throttled && gnt_any;
    assign req_ready = grant ? {{(N_REQ-1){1'b0}}, 1'b1} << gnt : '0;

    // first valid requester at or after rr_ptr, wrapping
    always_comb begin
        gnt = '0;
        gnt_any = 1'b0;
        j = 0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            j = int'(rr_ptr) + i;
            j = j >= int'(N_REQ) ? j - int'(N_REQ) : j;
            if (!gnt_any && req_valid[j]) begin
                gnt = 3'(j);
                gnt_any = 1'b1;
            end
        end
    end

    // kill outranks every other decision; reject codes are registered so the
    // pulse lines up with the state (HALT/IDLE) the decision leads to
    always_comb begin
        nxt = state;
        rej_n = 1'b0;
        code_n = 2'd0;
        case (state)
            IDLE: nxt = kill ? HALT : grant ? CHECK : IDLE;
            CHECK: begin
                code_n = kill ? 2'd3 : h_price > price_limit ? 2'd1 :
                         (h_qty == 16'd0 || h_qty > MAX_QTY) ? 2'd2 : 2'd0;
                rej_n = code_n != 2'd0;
                nxt = (code_n == 2'd3 || code_n == 2'd1) ? HALT : rej_n ? IDLE : ISSUE;
            end
            ISSUE: begin
                rej_n = kill && !out_ready;
                code_n = rej_n ? 2'd3 : 2'd0;
                nxt = kill ? HALT : out_ready ? IDLE : ISSUE;
            end
            default: nxt = rearm && !kill ? IDLE : HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            win_cnt   <= '0;
            ord_cnt   <= '0;
            h_price   <= '0;
            h_qty     <= '0;
            h_src     <= '0;
            rej_valid <= 1'b0;
            rej_src   <= '0;
            rej_code  <= '0;
        end else begin
            state     <= nxt;
            win_cnt   <= wrap ? '0 : win_cnt + 32'd1;
            // a handshake in the wrap cycle belongs to the new window
            ord_cnt   <= (wrap ? '0 : ord_cnt) + {31'd0, hs};
            rej_valid <= rej_n;
            rej_src   <= rej_n ? h_src : '0;
            rej_code  <= code_n;
            if (grant) begin
                h_price <= req_price[32*gnt +: 32];
                h_qty   <= req_qty[16*gnt +: 16];
                h_src   <= gnt;
                rr_ptr  <= gnt == 3'(N_REQ - 1) ? '0 : gnt + 3'd1;
            end
        end
    end

`ifdef RISK_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_accepted  <= '0;
            stat_rej_price <= '0;
            stat_rej_qty   <= '0;
            stat_killed    <= '0;
        end else begin
            if (hs && stat_accepted != '1) stat_accepted <= stat_accepted + 32'd1;
            if (rej_valid && rej_code == 2'd1 && stat_rej_price != '1) stat_rej_price <= stat_rej_price + 32'd1;
            if (rej_valid && rej_code == 2'd2 && stat_rej_qty != '1) stat_rej_qty <= stat_rej_qty + 32'd1;
            if (rej_valid && rej_code == 2'd3 && stat_killed != '1) stat_killed <= stat_killed + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_risk_order_sequencer.sv
// tb_risk_order_sequencer: randomized scoreboard bench for risk_order_sequencer
module tb_risk_order_sequencer;
    localparam int N = 4;
    localparam int W = 20;
    localparam int M = 2;
    localparam int LIM = 15000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic [32*N-1:0] req_price = '0;
    logic [16*N-1:0] req_qty = '0;
    logic [31:0] price_limit = 32'(LIM);
    logic kill = 1'b0, rearm = 1'b0, out_ready = 1'b0;
    logic out_valid, rej_valid, halted, throttled;
    logic [31:0] out_price;
    logic [15:0] out_qty;
    logic [2:0] out_src, rej_src;
    logic [1:0] rej_code;
`ifdef RISK_SEQ_STATS_EN
    logic [31:0] stat_accepted, stat_rej_price, stat_rej_qty, stat_killed;
`endif

    risk_order_sequencer #(
        .N_REQ(N), .MAX_QTY(16'd10000), .WINDOW_CYCLES(W), .MAX_ORDERS(M)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_price(req_price), .req_qty(req_qty), .price_limit(price_limit),
        .kill(kill), .rearm(rearm), .out_valid(out_valid), .out_ready(out_ready),
        .out_price(out_price), .out_qty(out_qty), .out_src(out_src),
        .rej_valid(rej_valid), .rej_src(rej_src), .rej_code(rej_code),
        .halted(halted), .throttled(throttled)
`ifdef RISK_SEQ_STATS_EN
        , .stat_accepted(stat_accepted), .stat_rej_price(stat_rej_price),
        .stat_rej_qty(stat_rej_qty), .stat_killed(stat_killed)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // expected outcome of one granted order: code 0 = approved, else reject code
    typedef struct {
        int src;
        logic [31:0] price;
        logic [15:0] qty;
        int code;
        int g;
        int due;
    } exp_t;

    exp_t q[$];
    int k = 0, m_rr = 0, m_cnt = 0, n_acc = 0;
    int n_rej[4] = '{0, 0, 0, 0};
    bit m_halt = 1'b0, post = 1'b0;
    logic [N-1:0] granted = '0;

    // monitor / reference model: k counts cycles since reset release
    always @(negedge clk) begin
        bit hs, nh, exp_ov, exp_rv, can;
        int eg, jj;
        exp_t e;
        logic [N-1:0] exp_rdy;
        hs = 1'b0; nh = 1'b0; exp_ov = 1'b0; exp_rv = 1'b0; can = 1'b0;
        eg = -1; jj = 0; e = '{0, 32'd0, 16'd0, 0, 0, -1}; exp_rdy = '0;
        if (rst) begin
            q.delete();
            k = 0; m_rr = 0; m_cnt = 0; m_halt = 1'b0; granted = '0; post = 1'b1;
            n_acc = 0; n_rej = '{0, 0, 0, 0};
        end else begin
            if (post) begin
                chk("post_reset_outputs", {out_valid, out_price, out_qty, out_src, rej_valid,
                    rej_src, rej_code, halted, throttled, req_ready}, 64'd0);
                post = 1'b0;
            end
            chk("halted", halted, m_halt);
            chk("throttled", throttled, m_cnt == M);
            exp_ov = q.size() > 0 && q[0].code == 0 && k >= q[0].g + 2;
            chk("out_valid", out_valid, exp_ov);
            if (out_valid && exp_ov) begin
                chk("out_fields", {out_src, out_price, out_qty}, {3'(q[0].src), q[0].price, q[0].qty});
                if (out_ready) begin
                    hs = 1'b1;
                    n_acc++;
                    void'(q.pop_front());
                end
            end
            exp_rv = q.size() > 0 && q[0].code != 0 && q[0].due == k;
            chk("rej_valid", rej_valid, exp_rv);
            if (exp_rv) begin
                if (rej_valid) chk("rej_fields", {rej_src, rej_code}, {3'(q[0].src), 2'(q[0].code)});
                n_rej[q[0].code]++;
                void'(q.pop_front());
            end
            for (int i = 0; i < N; i++) begin
                jj = (m_rr + i) % N;
                if (req_valid[jj]) begin
                    eg = jj;
                    break;
                end
            end
            can = q.size() == 0 && !hs && !m_halt && !kill && m_cnt < M && eg >= 0;
            if (can) exp_rdy[eg] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            granted = req_ready;
            if (can) begin
                e.src = eg;
                e.price = req_price[32*eg +: 32];
                e.qty = req_qty[16*eg +: 16];
                e.g = k;
                e.code = e.price > price_limit ? 1 : (e.qty == 16'd0 || e.qty > 16'd10000) ? 2 : 0;
                e.due = e.code != 0 ? k + 2 : -1;
                q.push_back(e);
                m_rr = (eg + 1) % N;
            end
            nh = m_halt;
            if (kill) begin
                nh = 1'b1;
                if (q.size() > 0) begin
                    e = q[0];
                    e.code = 3;
                    e.due = k + 1;
                    q[0] = e;
                end
            end else if (m_halt && rearm) nh = 1'b0;
            else if (q.size() > 0 && q[0].code == 1 && k == q[0].g + 1) nh = 1'b1;
            m_cnt = (k % W == W - 1) ? int'(hs) : m_cnt + int'(hs);
            m_halt = nh;
            k++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (granted[i]) req_valid[i] = 1'b0;
    endtask

    task automatic put(input int i, input logic [31:0] p, input logic [15:0] qn);
        req_valid[i] = 1'b1;
        req_price[32*i +: 32] = p;
        req_qty[16*i +: 16] = qn;
    endtask

    task automatic rand_order(input int i);
        int r, s;
        logic [31:0] p;
        logic [15:0] qn;
        r = int'($urandom_range(19));
        s = int'($urandom_range(19));
        p = r == 0 ? 32'(LIM + 1) + $urandom_range(1000) : r == 1 ? 32'(LIM) :
            r == 2 ? 32'(LIM - 1) : 32'($urandom_range(LIM));
        qn = s == 0 ? 16'd0 : s == 1 ? 16'd10001 : s == 2 ? 16'd10000 :
             s == 3 ? 16'hFFFF : 16'($urandom_range(10000, 1));
        put(i, p, qn);
    endtask

    task automatic wait_ov();
        int n;
        n = 0;
        while (!out_valid && n < 80) begin
            cyc();
            n++;
        end
        chk("wait_out_valid", out_valid, 1'b1);
    endtask

    initial begin
        bit prev_rst;
        int flip;
        prev_rst = 1'b0;
        flip = 0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        // single order and price-at-limit boundary
        out_ready = 1'b1;
        put(0, 32'(LIM - 1), 16'd100);
        repeat (4) cyc();
        put(1, 32'(LIM), 16'd50);
        repeat (25) cyc();
        // over-limit: reject 1 then HALT; rearm under kill is ignored
        put(2, 32'(LIM + 1), 16'd5);
        repeat (4) cyc();
        put(3, 32'd1234, 16'd9);
        kill = 1'b1;
        cyc();
        rearm = 1'b1;
        cyc();
        rearm = 1'b0;
        kill = 1'b0;
        repeat (2) cyc();
        rearm = 1'b1;
        cyc();
        rearm = 1'b0;
        repeat (25) cyc();
        // all requesters busy; requester 2 alternates qty 0 / 10001
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    if (i == 2) begin
                        put(i, 32'd1000, flip[0] ? 16'd10001 : 16'd0);
                        flip++;
                    end else put(i, 32'(1000 + i), 16'(100 + i));
                end
            end
            cyc();
        end
        repeat (70) cyc();
        // kill while held in ISSUE without handshake
        out_ready = 1'b0;
        put(1, 32'd2000, 16'd7);
        wait_ov();
        kill = 1'b1;
        cyc();
        kill = 1'b0;
        cyc();
        rearm = 1'b1;
        cyc();
        rearm = 1'b0;
        // kill coinciding with the handshake: order completes
        put(2, 32'd2001, 16'd8);
        wait_ov();
        out_ready = 1'b1;
        kill = 1'b1;
        cyc();
        kill = 1'b0;
        out_ready = 1'b0;
        cyc();
        rearm = 1'b1;
        cyc();
        rearm = 1'b0;
        // reset while in ISSUE
        put(3, 32'd2002, 16'd9);
        wait_ov();
        rst = 1'b1;
        req_valid = '0;
        cyc();
        rst = 1'b0;
        cyc();
        // randomized phases
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 800; c++) begin
                cyc();
                rst = ph == 3 && !prev_rst && $urandom_range(999) < 4;
                if (rst) req_valid = '0;
                else if (!prev_rst)
                    for (int i = 0; i < N; i++) if (!req_valid[i] && $urandom_range(99) < 30) rand_order(i);
                prev_rst = rst;
                out_ready = $urandom_range(99) < (ph == 1 ? 30 : 80);
                kill = ph >= 2 && $urandom_range(99) < 2;
                rearm = $urandom_range(99) < 10;
            end
        end
        rst = 1'b0;
        kill = 1'b0;
        out_ready = 1'b1;
        rearm = 1'b1;
        cyc();
        rearm = 1'b0;
        repeat (100) cyc();
`ifdef RISK_SEQ_STATS_EN
        chk("stat_accepted", stat_accepted, 64'(n_acc));
        chk("stat_rej_price", stat_rej_price, 64'(n_rej[1]));
        chk("stat_rej_qty", stat_rej_qty, 64'(n_rej[2]));
        chk("stat_killed", stat_killed, 64'(n_rej[3]));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
